// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory port between fetch, data and loader.
// Define MEM_ARB_LOADER_EN to enable the boot/reload loader path.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_done,
  output logic          ld_gnt,
  output logic          cpu_hold,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    conflict_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN,
    S_LOAD
  } state_t;

  state_t     state;
  logic       run;
  logic [1:0] rd_tag;

`ifdef MEM_ARB_LOADER_EN
  state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_BOOT,
      S_LOAD:  if (ld_done) state_nxt = S_RUN;
      S_RUN:   if (ld_req) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_LOAD;
      default: state_nxt = S_RUN;
    endcase
  end

  assign ld_gnt   = ~rst & ld_req
                  & ((state == S_BOOT) | (state == S_LOAD));
  assign cpu_hold = (state != S_RUN);
`else
  logic ld_unused;

  assign state     = S_RUN;
  assign ld_gnt    = 1'b0;
  assign cpu_hold  = 1'b0;
  assign ld_unused = ^{ld_req, ld_done, ld_addr, ld_wdata};
`endif

  // Grants are gated by rst so every port idles while reset is held.
  assign run    = ~rst & (state == S_RUN);
  assign d_gnt  = run & d_req;
  assign if_gnt = run & if_req & ~d_req;
  assign mem_en = if_gnt | d_gnt | ld_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      d_gnt: begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      if_gnt: begin
        mem_addr  = if_addr;
      end
      ld_gnt: begin
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      default: ;
    endcase
  end

  // Tag bit 1 marks a data read, bit 0 a fetch read, returning next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_tag <= 2'b00;
    else     rd_tag <= {d_gnt & ~d_we, if_gnt};
  end

  assign if_rvalid = rd_tag[0];
  assign d_rvalid  = rd_tag[1];
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 8'd0;
    end else if (run & if_req & d_req & ~&conflict_cnt) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural memory and
// arbitration model; works with or without MEM_ARB_LOADER_EN.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_LOADER_EN
  localparam bit LD_EN = 1'b1;
`else
  localparam bit LD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req, if_gnt, if_rvalid;
  logic [7:0] if_addr, if_rdata;
  logic       d_req, d_we, d_gnt, d_rvalid;
  logic [7:0] d_addr, d_wdata, d_rdata;
  logic       ld_req, ld_done, ld_gnt;
  logic [7:0] ld_addr, ld_wdata;
  logic       cpu_hold, mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_gnt(ld_gnt), .cpu_hold(cpu_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Memory environment: unwritten bytes read as addr ^ 0x5C.
  logic [7:0] bmem [256];
  bit         bwr  [256];

  always @(posedge clk) begin
    if (mem_en & mem_we) begin
      bmem[mem_addr] <= mem_wdata;
      bwr[mem_addr]  <= 1'b1;
    end
    if (mem_en & ~mem_we)
      mem_rdata <= bwr[mem_addr] ? bmem[mem_addr] : (mem_addr ^ 8'h5C);
  end

  // Reference model
  logic [7:0] ref_mem [256];
  bit         m_hold, m_drain;
  int         m_cnt;
  logic [7:0] exp_if_q [$];
  logic [7:0] exp_d_q  [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (if_rvalid) begin
        if (exp_if_q.size() == 0) chk("if_rvalid_unexpected", if_rvalid, 0);
        else chk("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (d_rvalid) begin
        if (exp_d_q.size() == 0) chk("d_rvalid_unexpected", d_rvalid, 0);
        else chk("d_rdata", d_rdata, exp_d_q.pop_front());
      end
    end
  end

  task automatic cycle(
    input logic ifr, input logic [7:0] ifa,
    input logic dr, input logic dwe, input logic [7:0] da, input logic [7:0] dwd,
    input logic ldr, input logic [7:0] lda, input logic [7:0] ldwd,
    input logic ldd,
    output logic gi, output logic gd, output logic gl);
    logic e_if, e_d, e_ld, e_we;
    logic [7:0] e_addr, e_wd;
    @(negedge clk);
    if_req = ifr; if_addr = ifa;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    ld_req = ldr; ld_addr = lda; ld_wdata = ldwd; ld_done = ldd;
    #2;
    e_if = 1'b0; e_d = 1'b0; e_ld = 1'b0;
    if (!m_hold) begin
      e_d  = dr;
      e_if = ifr & ~dr;
    end else if (!m_drain) begin
      e_ld = ldr & LD_EN;
    end
    chk("if_gnt", if_gnt, e_if);
    chk("d_gnt", d_gnt, e_d);
    chk("ld_gnt", ld_gnt, e_ld);
    chk("cpu_hold", cpu_hold, m_hold);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("mem_en", mem_en, e_if | e_d | e_ld);
    if (e_if | e_d | e_ld) begin
      e_addr = e_d ? da : (e_if ? ifa : lda);
      e_we   = e_d ? dwe : e_ld;
      e_wd   = e_d ? dwd : ldwd;
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      if (e_we) chk("mem_wdata", mem_wdata, e_wd);
    end else begin
      chk("mem_we_idle", mem_we, 0);
    end
    if (e_if) exp_if_q.push_back(ref_mem[ifa]);
    if (e_d && !dwe) exp_d_q.push_back(ref_mem[da]);
    if (e_d && dwe) ref_mem[da] = dwd;
    if (e_ld) ref_mem[lda] = ldwd;
    if (!m_hold) begin
      if (ifr && dr && m_cnt < 255) m_cnt++;
      if (ldr && LD_EN) begin
        m_hold  = 1'b1;
        m_drain = 1'b1;
      end
    end else if (m_drain) begin
      m_drain = 1'b0;
    end else if (ldd) begin
      m_hold = 1'b0;
    end
    gi = e_if; gd = e_d; gl = e_ld;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_if_q.delete();
    exp_d_q.delete();
    m_hold = LD_EN; m_drain = 1'b0; m_cnt = 0;
    @(negedge clk);
    #2;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_cpu_hold", cpu_hold, LD_EN);
    if_req = 0; d_req = 0; ld_req = 0; ld_done = 0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_if_rvalid", if_rvalid, 0);
    chk("post_rst_d_rvalid", d_rvalid, 0);
  endtask

  logic       gi, gd, gl;
  bit         pif, pd, pld;
  logic       rdwe, ldd;
  logic [7:0] rifa, rda, rdwd, rlda, rldwd;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5C;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    ld_req = 0; ld_addr = 0; ld_wdata = 0; ld_done = 0;
    apply_reset();

    // program load, then fetch the first byte
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h88, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h01, 8'h89, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h02, 8'h24, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, gi, gd, gl);
    cycle(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);

    // fetch/data conflict, then fetch wins
    cycle(1, 8'h01, 1, 0, 8'hFF, 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(1, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);

    // data write then read back
    cycle(0, 0, 1, 1, 8'hFE, 8'h5A, 0, 0, 0, 0, gi, gd, gl);
    cycle(0, 0, 1, 0, 8'hFE, 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);

    // reload request while a fetch is granted
    cycle(1, 8'h08, 0, 0, 0, 0, 1, 8'h10, 8'h77, 0, gi, gd, gl);
    cycle(1, 8'h09, 1, 0, 8'h02, 0, 1, 8'h10, 8'h77, 0, gi, gd, gl);
    cycle(1, 8'h09, 1, 0, 8'h02, 0, 1, 8'h10, 8'h77, 0, gi, gd, gl);
    cycle(1, 8'h09, 1, 0, 8'h02, 0, 0, 0, 0, 1, gi, gd, gl);
    cycle(1, 8'h09, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(1, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);

    // randomized traffic with requests held until granted
    pif = 0; pd = 0; pld = 0;
    rifa = 0; rda = 0; rdwd = 0; rdwe = 0; rlda = 0; rldwd = 0;
    for (int k = 0; k < 1200; k++) begin
      if (k < 1000) begin
        if (!pif && $urandom_range(2) != 0) begin
          pif = 1; rifa = 8'($urandom);
        end
        if (!pd && $urandom_range(3) == 0) begin
          pd = 1; rdwe = 1'($urandom_range(1));
          rda = 8'($urandom); rdwd = 8'($urandom);
        end
        if (LD_EN) begin
          if (!pld && $urandom_range(59) == 0) begin
            pld = 1; rlda = 8'($urandom); rldwd = 8'($urandom);
          end
        end else begin
          pld = 1'($urandom_range(1));
          rlda = 8'($urandom); rldwd = 8'($urandom);
        end
      end else if (!LD_EN) begin
        pld = 0;
      end
      if (k >= 1000 && !pif && !pd && !pld && !m_hold) break;
      ldd = ($urandom_range(5) == 0) && (!LD_EN || (m_hold && !m_drain));
      cycle(pif, rifa, pd, rdwe, rda, rdwd, pld, rlda, rldwd, ldd,
            gi, gd, gl);
      if (gi) pif = 0;
      if (gd) pd = 0;
      if (gl) pld = 0;
    end
    chk("flush_pending", {29'd0, pif, pd, pld}, 0);
    chk("flush_hold", cpu_hold, 0);

    // continuous conflict saturates the counter
    repeat (300)
      cycle(1, 8'h20, 1, 0, 8'($urandom), 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);
    chk("cnt_saturated", conflict_cnt, 8'hFF);

    // reset right after a fetch grant: no read may return
    cycle(1, 8'h30, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);
    chk("pre_rst_grant", if_gnt, 1);
    apply_reset();

    cycle(1, 8'h31, 0, 0, 0, 0, 1, 8'h31, 8'hC3, 0, gi, gd, gl);
    cycle(1, 8'h31, 0, 0, 0, 0, 0, 0, 0, 1, gi, gd, gl);
    cycle(1, 8'h31, 1, 0, 8'hFE, 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(1, 8'h31, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd, gl);
    chk("if_queue_drained", exp_if_q.size(), 0);
    chk("d_queue_drained", exp_d_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU's single-port unified instruction/data memory between three requesters: the fetch stage, the memory stage (LDD/STD/PUSH/POP/LDI/STI), and a program loader. A small FSM holds the pipeline in reset-like stall while the loader writes a program, then hands the memory to the CPU. Sits between the pipeline front/back ends and `mem_inst`, replacing direct wiring of fetch and data ports to memory.

## Interface
- `AW`, 8, address width (256-byte space)
- `DW`, 8, data width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `if_req`  in  1  fetch read request
- `if_addr`  in  AW  fetch address (PC)
- `if_gnt`  out  1  fetch granted this cycle (combinational)
- `if_rvalid`  out  1  fetch data valid (one cycle after grant)
- `if_rdata`  out  DW  fetch data
- `d_req`, `d_we`  in  1 each  data request, write enable
- `d_addr`  in  AW; `d_wdata`  in  DW
- `d_gnt`  out  1; `d_rvalid`  out  1; `d_rdata`  out  DW
- `ld_req`  in  1  loader write request
- `ld_addr`  in  AW; `ld_wdata`  in  DW
- `ld_done`  in  1  loader finished (single-cycle pulse)
- `ld_gnt`  out  1  loader write accepted
- `cpu_hold`  out  1  stall entire pipeline (PC and pipeline registers freeze)
- `mem_en`, `mem_we`  out  1 each; `mem_addr`  out  AW; `mem_wdata`  out  DW
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_en & ~mem_we`
- `conflict_cnt`  out  8  saturating count of cycles `if_req` was denied by `d_req`

## Operation
- States: BOOT, RUN, DRAIN, LOAD.
- BOOT: `cpu_hold=1`; only loader served; `ld_gnt = ld_req`. `ld_done` -> RUN.
- RUN: `cpu_hold=0`; fixed priority `d_req` > `if_req`. Exactly one grant per cycle. `ld_req` in RUN -> DRAIN (no grant to loader that cycle; CPU grant still issued).
- DRAIN: `cpu_hold=1`; no new CPU grants; lasts exactly one cycle to return any outstanding read -> LOAD.
- LOAD: same as BOOT; `ld_done` -> RUN.
- `ld_done` and `ld_req` in same cycle: write is granted, then transition.
- Memory drive: granted requester's addr/wdata/we muxed onto `mem_*`; `mem_en = |{if_gnt,d_gnt,ld_gnt}`. Loader grant always write; fetch grant always read.
- Read return: a registered 2-bit tag (fetch/data) records the read granted; next cycle the matching `*_rvalid=1` and `*_rdata = mem_rdata`. Both `rdata` outputs show `mem_rdata` unconditionally; only `rvalid` qualifies.
- Data writes produce no `d_rvalid`.
- `conflict_cnt`: increments when `if_req & d_req` in RUN; saturates at 0xFF; clears only on reset.
- Requesters hold req/addr/wdata stable until granted.

## Timing
- Grant is combinational on request, same cycle; read latency 1 cycle grant-to-rvalid; throughput 1 access/cycle.
- Reset values: state BOOT (macro defined) or RUN (undefined); all `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0; `conflict_cnt`=0; `cpu_hold`=1 (defined) / 0 (undefined).
- Reset asserted mid-read: pending tag cleared, no `rvalid` after deassert.
- `cpu_hold` rises the cycle after `ld_req` sampled in RUN; falls the cycle after `ld_done`.
- Back-to-back `d_req` starves fetch indefinitely; by design (memory-stage always finishes).

## Configuration
- `MEM_ARB_LOADER_EN`: defined -> BOOT/DRAIN/LOAD states and loader port active; reset enters BOOT with `cpu_hold=1`. Undefined -> FSM fixed in RUN, `ld_*` inputs ignored, `ld_gnt=0`, `cpu_hold=0`; port list unchanged.

## Test plan
- Reset, loader writes 0x88,0x89,0x24 at 0x00–0x02, pulse `ld_done` -> three `ld_gnt` cycles with `cpu_hold=1`, then `cpu_hold=0`; fetch at 0x00 returns 0x88 on `if_rvalid` next cycle.
- RUN, `if_req`+`d_req` (read 0xFF) same cycle -> `d_gnt=1`, `if_gnt=0`, `conflict_cnt` 0->1; next cycle `d_rvalid=1`, fetch granted.
- Data write 0x5A to 0xFE -> `mem_we=1`, no `d_rvalid`; later data read 0xFE -> `d_rdata=0x5A`.
- `ld_req` in RUN with fetch read granted same cycle -> `if_rvalid` still returned during DRAIN; no CPU grant in DRAIN; LOAD entered next.
- 300 cycles continuous conflict -> `conflict_cnt` saturates at 0xFF.
- `rst` pulsed the cycle after a fetch grant -> `if_rvalid` stays 0, all outputs at reset values.
